dmux8way_sched: RTL and testbench

- Sequencer for the 1-to-8 demultiplexer: takes a single valid/ready word stream and distributes it to eight consumer channels through a one-entry registered output stage.
- Drives the one-hot per-channel valid (the demux function) and the shared data bus.
- Channel order is either round-robin with a configurable burst length per turn, or a fixed select.
- Sits between a single producer and eight downstream sinks.

---
 rtl/dmux8way_sched_if.sv | 26 ++
 rtl/dmux8way_sched.sv | 116 +++++++++++
 tb/tb_dmux8way_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmux8way_sched_if.sv
// Handshake bundle for dmux8way_sched.
//   Producer side : in_valid, in_data -> in_ready
//   Consumer side : out_data, out_valid[7:0] -> out_ready[7:0]
// Modports:
//   slave  - the sequencer itself (accepts the input stream, drives the channels)
//   master - the environment (producer and the eight sinks)
interface dmux8way_sched_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dmux8way_sched.sv
// dmux8way_sched: distributes a single valid/ready word stream to eight
// consumer channels through a one-entry registered output stage.
// Channel order is round-robin with BURST words per turn, or a fixed select.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   bus (slave)   - in_valid/in_data/in_ready, out_data/out_valid[7:0]/out_ready[7:0]
//   cfg_mode      - 0 = round-robin, 1 = fixed select
//   cfg_sel       - target channel in fixed mode
//   cfg_mask      - channel enable mask
//   cur_sel       - channel of the held / most recently loaded word
//   busy          - output buffer holds a word
module dmux8way_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmux8way_sched_if.slave      bus,
  input  logic                 cfg_mode,
  input  logic [2:0]           cfg_sel,
  input  logic [7:0]           cfg_mask,
  output logic [2:0]           cur_sel,
  output logic                 busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_reg;
  logic [DW-1:0] out_data_reg;
  logic [7:0]    out_valid_reg;
  logic [2:0]    cur_sel_reg;
  logic [4:0]    burst_left_reg;
  logic          busy_reg;

  logic       eligible;
  logic       rel_fire;
  logic       in_ready_w;
  logic       load;
  logic [2:0] rr_next;
  logic       rr_found;
  logic [2:0] sel_next;
  logic [4:0] burst_next;
  logic [7:0] sel_onehot;

  always_comb begin
    eligible   = cfg_mode ? cfg_mask[cfg_sel] : (cfg_mask != 8'h00);
    rel_fire   = (state_reg == FULL) && bus.out_ready[cur_sel_reg];
    // Refill in the same cycle as a release keeps one word per cycle.
    in_ready_w = eligible && ((state_reg == EMPTY) || rel_fire);
    load       = bus.in_valid && in_ready_w;
  end

  // Next enabled channel strictly after cur_sel, wrapping. The k=8 step lands
  // back on cur_sel so a lone enabled channel re-selects itself. From the
  // reset value 7 the search naturally starts at channel 0.
  always_comb begin
    rr_next  = cur_sel_reg;
    rr_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!rr_found && cfg_mask[3'(cur_sel_reg + 3'(k))]) begin
        rr_next  = 3'(cur_sel_reg + 3'(k));
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (cfg_mode) begin
      // burst_left cleared so that returning to round-robin advances at once
      sel_next   = cfg_sel;
      burst_next = 5'd0;
    end else if ((burst_left_reg != 5'd0) && cfg_mask[cur_sel_reg]) begin
      sel_next   = cur_sel_reg;
      burst_next = burst_left_reg - 5'd1;
    end else begin
      sel_next   = rr_next;
      burst_next = 5'(BURST - 1);
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_next == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      out_data_reg   <= '0;
      out_valid_reg  <= 8'h00;
      cur_sel_reg    <= 3'd7;
      burst_left_reg <= 5'd0;
      busy_reg       <= 1'b0;
    end else if (load) begin
      state_reg      <= FULL;
      out_data_reg   <= bus.in_data;
      out_valid_reg  <= sel_onehot;
      cur_sel_reg    <= sel_next;
      burst_left_reg <= burst_next;
      busy_reg       <= 1'b1;
    end else if (rel_fire) begin
      // out_data and cur_sel keep their last values after a drain
      state_reg     <= EMPTY;
      out_valid_reg <= 8'h00;
      busy_reg      <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign cur_sel       = cur_sel_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_dmux8way_sched.sv
module tb_dmux8way_sched;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic       clk;
  logic       rst_n;
  logic       cfg_mode;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_mask;
  logic [2:0] cur_sel;
  logic       busy;

  dmux8way_sched_if #(.DW(DW)) bus ();

  dmux8way_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cfg_mode (cfg_mode),
    .cfg_sel  (cfg_sel),
    .cfg_mask (cfg_mask),
    .cur_sel  (cur_sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the buffer holds and which channel it belongs to.
  bit          m_full;
  logic [7:0]  m_data;
  int          m_sel;
  int          m_burst;
  int          log_ch[$];
  int          log_dat[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_full  = 1'b0;
    m_data  = 8'h00;
    m_sel   = 7;
    m_burst = 0;
  endfunction

  // Called at posedge+1; drops reset between edges and checks the
  // asynchronous effect before any clock edge arrives.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_out_valid", {24'd0, bus.out_valid}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cur_sel", {29'd0, cur_sel}, 32'd7);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, check against model mid-cycle, advance model.
  task automatic step(input bit iv, input logic [7:0] id, input bit md,
                      input logic [2:0] sl, input logic [7:0] mk, input logic [7:0] ordy);
    bit         elig, rel, exp_ir;
    logic [7:0] exp_ov;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    cfg_mode      = md;
    cfg_sel       = sl;
    cfg_mask      = mk;
    #4;
    exp_ov = m_full ? (8'h01 << m_sel) : 8'h00;
    elig   = md ? mk[sl] : (mk != 8'h00);
    rel    = m_full && ordy[m_sel];
    exp_ir = elig && (!m_full || rel);
    check_eq("out_valid", {24'd0, bus.out_valid}, {24'd0, exp_ov});
    check_eq("busy", {31'd0, busy}, {31'd0, m_full});
    check_eq("cur_sel", {29'd0, cur_sel}, 32'(m_sel));
    check_eq("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
    check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ir});
    if (rel) begin
      log_ch.push_back(m_sel);
      log_dat.push_back(int'(m_data));
    end
    if (iv && exp_ir) begin
      m_data = id;
      m_full = 1'b1;
      if (md) begin
        m_sel   = int'(sl);
        m_burst = 0;
      end else if (m_burst != 0 && mk[m_sel]) begin
        m_burst = m_burst - 1;
      end else begin
        for (int k = 1; k <= 8; k++) begin
          if (mk[(m_sel + k) % 8]) begin
            m_sel = (m_sel + k) % 8;
            break;
          end
        end
        m_burst = BURST - 1;
      end
    end else if (rel) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 8'h00;
    cfg_mode      = 1'b0;
    cfg_sel       = 3'd0;
    cfg_mask      = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Round-robin streaming, 12 back-to-back words.
    log_ch.delete();
    log_dat.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0, 3'd0, 8'hFF, 8'hFF);
    step(1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 8'hFF);
    check_eq("stream_count", 32'(log_ch.size()), 32'd12);
    for (int i = 0; i < 12 && i < log_ch.size(); i++) begin
      check_eq("stream_ch", 32'(log_ch[i]), 32'(i / 4));
      check_eq("stream_dat", 32'(log_dat[i]), 32'(i));
    end

    // Mid-stream reset with a word held.
    step(1'b1, 8'h3C, 1'b0, 3'd0, 8'hFF, 8'h00);
    do_reset();

    // Backpressure on channel 0; channel 1 ready is ignored.
    step(1'b1, 8'hA5, 1'b0, 3'd0, 8'hFF, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h11, 1'b0, 3'd0, 8'hFF, 8'h02);
      check_eq("bp_data", {24'd0, bus.out_data}, 32'hA5);
      check_eq("bp_valid", {24'd0, bus.out_valid}, 32'h01);
    end
    log_ch.delete();
    log_dat.delete();
    step(1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 8'h01);
    check_eq("bp_drained", {24'd0, bus.out_valid}, 32'h00);
    check_eq("bp_released", 32'(log_dat.size() == 1 ? log_dat[0] : -1), 32'hA5);

    // Fixed mode on channel 5.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h50 + i), 1'b1, 3'd5, 8'hFF, 8'hFF);
      check_eq("fixed_valid", {24'd0, bus.out_valid}, 32'h20);
    end
    step(1'b1, 8'h99, 1'b1, 3'd5, 8'hDF, 8'h00);
    check_eq("fixed_masked_ir", {31'd0, bus.in_ready}, 32'd0);
    step(1'b1, 8'h99, 1'b1, 3'd5, 8'hDF, 8'h20);
    check_eq("fixed_masked_drain", {31'd0, busy}, 32'd0);

    // Return to round-robin advances past channel 5.
    step(1'b1, 8'h77, 1'b0, 3'd0, 8'hFF, 8'hFF);
    check_eq("mode_switch_sel", {29'd0, cur_sel}, 32'd6);
    check_eq("mode_switch_valid", {24'd0, bus.out_valid}, 32'h40);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] mk;
      logic [7:0] ordy;
      int         r;
      r = int'($urandom_range(0, 9));
      if (r < 4)       mk = 8'hFF;
      else if (r < 6)  mk = 8'(8'h01 << $urandom_range(0, 7));
      else if (r < 7)  mk = 8'h00;
      else             mk = 8'($urandom);
      r = int'($urandom_range(0, 3));
      ordy = (r == 0) ? 8'($urandom) : 8'hFF;
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           3'($urandom), mk, ordy);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
